// File: rtl/vx_mem_perf_monitor.sv
// Multi-channel memory performance monitor: request/response counts, outstanding reads and
// accumulated read latency. Optional high-water mark via the VX_MEM_PERF_PEAK_EN macro.
module vx_mem_perf_monitor #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned CTR_WIDTH    = 44,
  parameter int unsigned PEND_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [NUM_CHANNELS-1:0] req_rd_fire,
  input  logic [NUM_CHANNELS-1:0] req_wr_fire,
  input  logic [NUM_CHANNELS-1:0] rsp_fire,
  output logic [CTR_WIDTH-1:0]    perf_reads,
  output logic [CTR_WIDTH-1:0]    perf_writes,
  output logic [CTR_WIDTH-1:0]    perf_rsps,
  output logic [CTR_WIDTH-1:0]    perf_latency,
  output logic [PEND_WIDTH-1:0]   perf_pending,
  output logic [PEND_WIDTH-1:0]   perf_peak,
  output logic                    sat_flag,
  output logic                    underflow_flag
);

  localparam int unsigned CntW  = $clog2(NUM_CHANNELS + 1);
  localparam int unsigned AccW  = ((CTR_WIDTH > PEND_WIDTH) ? CTR_WIDTH : PEND_WIDTH) + 1;
  // Two spare bits so that pending + rd_cnt can never wrap before the range check.
  localparam int unsigned NextW = PEND_WIDTH + 2;

  localparam logic [CTR_WIDTH-1:0]  CtrMax  = '1;
  localparam logic [PEND_WIDTH-1:0] PendMax = '1;

  function automatic logic [CntW-1:0] popcount(input logic [NUM_CHANNELS-1:0] v);
    logic [CntW-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) c = c + CntW'(v[i]);
    return c;
  endfunction

  // Returns {overflow, saturated sum}.
  function automatic logic [CTR_WIDTH:0] sat_add(input logic [CTR_WIDTH-1:0] ctr,
                                                 input logic [AccW-1:0]      inc);
    logic [AccW-1:0] sum;
    sum = AccW'(ctr) + inc;
    if (sum > AccW'(CtrMax)) return {1'b1, CtrMax};
    return {1'b0, sum[CTR_WIDTH-1:0]};
  endfunction

  logic [NUM_CHANNELS-1:0] rd_fire_q, wr_fire_q, rsp_fire_q;
  logic [CntW-1:0]         rd_cnt, wr_cnt, rsp_cnt;
  logic [NextW-1:0]        pend_next;
  logic                    pend_neg, pend_ovf;
  logic [CTR_WIDTH:0]      reads_sum, writes_sum, rsps_sum, lat_sum;

  logic [CTR_WIDTH-1:0]  reads_q, reads_d, writes_q, writes_d;
  logic [CTR_WIDTH-1:0]  rsps_q, rsps_d, lat_q, lat_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic                  sat_q, sat_d, udf_q, udf_d;

  always_comb begin
    rd_cnt  = popcount(rd_fire_q);
    wr_cnt  = popcount(wr_fire_q);
    rsp_cnt = popcount(rsp_fire_q);

    pend_next = NextW'(pend_q) + NextW'(rd_cnt) - NextW'(rsp_cnt);
    pend_neg  = pend_next[NextW-1];
    pend_ovf  = !pend_neg && (pend_next > NextW'(PendMax));
    if (pend_neg)      pend_d = '0;
    else if (pend_ovf) pend_d = PendMax;
    else               pend_d = pend_next[PEND_WIDTH-1:0];

    reads_sum  = sat_add(reads_q,  AccW'(rd_cnt));
    writes_sum = sat_add(writes_q, AccW'(wr_cnt));
    rsps_sum   = sat_add(rsps_q,   AccW'(rsp_cnt));
    lat_sum    = sat_add(lat_q,    AccW'(pend_q));

    reads_d  = reads_q;
    writes_d = writes_q;
    rsps_d   = rsps_q;
    lat_d    = lat_q;
    sat_d    = sat_q | pend_ovf;
    udf_d    = udf_q | pend_neg;

    if (enable) begin
      reads_d  = reads_sum[CTR_WIDTH-1:0];
      writes_d = writes_sum[CTR_WIDTH-1:0];
      rsps_d   = rsps_sum[CTR_WIDTH-1:0];
      lat_d    = lat_sum[CTR_WIDTH-1:0];
      sat_d    = sat_d | reads_sum[CTR_WIDTH] | writes_sum[CTR_WIDTH]
                       | rsps_sum[CTR_WIDTH] | lat_sum[CTR_WIDTH];
    end

    // Pending is left alone: requests issued before the clear are still in flight.
    if (clear) begin
      reads_d  = '0;
      writes_d = '0;
      rsps_d   = '0;
      lat_d    = '0;
      sat_d    = 1'b0;
      udf_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_fire_q  <= '0;
      wr_fire_q  <= '0;
      rsp_fire_q <= '0;
      reads_q    <= '0;
      writes_q   <= '0;
      rsps_q     <= '0;
      lat_q      <= '0;
      pend_q     <= '0;
      sat_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      rd_fire_q  <= req_rd_fire;
      wr_fire_q  <= req_wr_fire;
      rsp_fire_q <= rsp_fire;
      reads_q    <= reads_d;
      writes_q   <= writes_d;
      rsps_q     <= rsps_d;
      lat_q      <= lat_d;
      pend_q     <= pend_d;
      sat_q      <= sat_d;
      udf_q      <= udf_d;
    end
  end

`ifdef VX_MEM_PERF_PEAK_EN
  logic [PEND_WIDTH-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = (pend_d > peak_q) ? pend_d : peak_q;
    if (clear) peak_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) peak_q <= '0;
    else          peak_q <= peak_d;
  end

  assign perf_peak = peak_q;
`else
  assign perf_peak = '0;
`endif

  assign perf_reads     = reads_q;
  assign perf_writes    = writes_q;
  assign perf_rsps      = rsps_q;
  assign perf_latency   = lat_q;
  assign perf_pending   = pend_q;
  assign sat_flag       = sat_q;
  assign underflow_flag = udf_q;

endmodule

// File: tb/tb_vx_mem_perf_monitor.sv
// Directed bench for vx_mem_perf_monitor: a default instance and a 4-bit-counter instance
// share the same stimulus. Inputs change and outputs are sampled on the falling clock edge.
module tb_vx_mem_perf_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] rd = '0, wr = '0, rsp = '0;

  logic [43:0] a_reads, a_writes, a_rsps, a_lat;
  logic [15:0] a_pend, a_peak;
  logic        a_sat, a_udf;
  logic [3:0]  s_reads, s_writes, s_rsps, s_lat;
  logic [15:0] s_pend, s_peak;
  logic        s_sat, s_udf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vx_mem_perf_monitor #(.NUM_CHANNELS(4), .CTR_WIDTH(44), .PEND_WIDTH(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .req_rd_fire(rd), .req_wr_fire(wr), .rsp_fire(rsp),
    .perf_reads(a_reads), .perf_writes(a_writes), .perf_rsps(a_rsps), .perf_latency(a_lat),
    .perf_pending(a_pend), .perf_peak(a_peak), .sat_flag(a_sat), .underflow_flag(a_udf)
  );

  vx_mem_perf_monitor #(.NUM_CHANNELS(4), .CTR_WIDTH(4), .PEND_WIDTH(16)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .enable(enable), .clear(clear),
    .req_rd_fire(rd), .req_wr_fire(wr), .rsp_fire(rsp),
    .perf_reads(s_reads), .perf_writes(s_writes), .perf_rsps(s_rsps), .perf_latency(s_lat),
    .perf_pending(s_pend), .perf_peak(s_peak), .sat_flag(s_sat), .underflow_flag(s_udf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " a_reads"},   64'(a_reads),  64'd0);
    check({tag, " a_writes"},  64'(a_writes), 64'd0);
    check({tag, " a_rsps"},    64'(a_rsps),   64'd0);
    check({tag, " a_latency"}, 64'(a_lat),    64'd0);
    check({tag, " a_pending"}, 64'(a_pend),   64'd0);
    check({tag, " a_peak"},    64'(a_peak),   64'd0);
    check({tag, " a_sat"},     64'(a_sat),    64'd0);
    check({tag, " a_udf"},     64'(a_udf),    64'd0);
    check({tag, " s_reads"},   64'(s_reads),  64'd0);
    check({tag, " s_writes"},  64'(s_writes), 64'd0);
    check({tag, " s_rsps"},    64'(s_rsps),   64'd0);
    check({tag, " s_latency"}, 64'(s_lat),    64'd0);
    check({tag, " s_pending"}, 64'(s_pend),   64'd0);
    check({tag, " s_peak"},    64'(s_peak),   64'd0);
    check({tag, " s_sat"},     64'(s_sat),    64'd0);
    check({tag, " s_udf"},     64'(s_udf),    64'd0);
  endtask

  initial begin
    // Reset and idle.
    tick(2);
    check_all_zero("in_reset");
    reset_n = 1'b1;
    tick(10);
    check_all_zero("idle");

    // Four reads, then responses 3 and 4 cycles after the request.
    rd = 4'b1111;
    tick(1);
    rd = 4'b0000;
    tick(1);
    check("pend_after_reads", 64'(a_pend), 64'd4);
    check("reads_after_reads", 64'(a_reads), 64'd4);
    tick(1);
    rsp = 4'b0011;
    tick(1);
    rsp = 4'b1100;
    tick(1);
    rsp = 4'b0000;
    tick(2);
    check("reads_total", 64'(a_reads), 64'd4);
    check("rsps_total", 64'(a_rsps), 64'd4);
    check("pend_drained", 64'(a_pend), 64'd0);
    // Pre-update pending summed over the edges it is non-zero: 4+4+4+2.
    check("latency_total", 64'(a_lat), 64'd14);
`ifdef VX_MEM_PERF_PEAK_EN
    check("peak", 64'(a_peak), 64'd4);
`else
    check("peak_tied", 64'(a_peak), 64'd0);
`endif
    check("udf_none", 64'(a_udf), 64'd0);

    // Underflow: response with nothing outstanding.
    rsp = 4'b0001;
    tick(1);
    rsp = 4'b0000;
    check("udf_not_yet", 64'(a_udf), 64'd0);
    tick(1);
    check("udf_set", 64'(a_udf), 64'd1);
    check("udf_pend_zero", 64'(a_pend), 64'd0);
    check("udf_rsps", 64'(a_rsps), 64'd5);

    // Clear zeroes accumulators and flags on the next edge.
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_reads", 64'(a_reads), 64'd0);
    check("clr_latency", 64'(a_lat), 64'd0);
    check("clr_udf", 64'(a_udf), 64'd0);
    check("clr_peak", 64'(a_peak), 64'd0);

    // Saturation on the 4-bit instance.
    wr = 4'b0001;
    tick(20);
    wr = 4'b0000;
    tick(1);
    check("wide_writes", 64'(a_writes), 64'd20);
    check("wide_sat", 64'(a_sat), 64'd0);
    check("narrow_writes", 64'(s_writes), 64'd15);
    check("narrow_sat", 64'(s_sat), 64'd1);

    // Enable/clear interplay.
    clear = 1'b1;
    tick(1);
    clear  = 1'b0;
    enable = 1'b0;
    rd     = 4'b0011;
    tick(1);
    rd = 4'b0000;
    tick(1);
    check("dis_reads", 64'(a_reads), 64'd0);
    check("dis_pend", 64'(a_pend), 64'd2);
    check("dis_latency", 64'(a_lat), 64'd0);
    clear  = 1'b1;
    enable = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clr_en_reads", 64'(a_reads), 64'd0);
    check("clr_en_latency", 64'(a_lat), 64'd0);
    check("clr_en_writes", 64'(a_writes), 64'd0);
    check("clr_en_pend", 64'(a_pend), 64'd2);
    rsp = 4'b0011;
    tick(1);
    rsp = 4'b0000;
    tick(1);
    check("en_rsps", 64'(a_rsps), 64'd2);
    check("en_pend", 64'(a_pend), 64'd0);
    check("en_latency", 64'(a_lat), 64'd4);

    // Request and response on the same channel in one cycle.
    rd  = 4'b0011;
    rsp = 4'b0001;
    tick(1);
    rd  = 4'b0000;
    rsp = 4'b0000;
    tick(1);
    check("same_pend", 64'(a_pend), 64'd1);
    check("same_reads", 64'(a_reads), 64'd2);
    check("same_rsps", 64'(a_rsps), 64'd3);
    check("same_udf", 64'(a_udf), 64'd0);
    rd = 4'b0011;
    tick(1);
    rd = 4'b0000;
    tick(1);
    check("pre_reset_pend", 64'(a_pend), 64'd3);

    // Async reset between edges with a read burst sitting in stage 1.
    rd = 4'b1111;
    tick(1);
    rd = 4'b0000;
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick(3);
    check("post_reset_pend", 64'(a_pend), 64'd0);
    check("post_reset_reads", 64'(a_reads), 64'd0);
    check("post_reset_latency", 64'(a_lat), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
